// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display driver:
// converter state encoding, BCD nibble width and active-low segment codes.
package display_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles map to blank so a corrupted digit never lights garbage
    function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/display_scan_driver_bcd.sv
// Sequential double-dabble converter: one IDLE capture cycle, BIN_W shift
// cycles and one LATCH cycle; bcd holds the last finished result.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BIN_W-1:0]          bin,
    output logic [DIGITS*BCD_W-1:0]   bcd,
    output logic                      done
);

    localparam int ACC_W = DIGITS * BCD_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    conv_state_t        r_state;
    conv_state_t        w_state_next;
    logic [BIN_W-1:0]   r_bin;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[gi*BCD_W +: BCD_W] = (r_acc[gi*BCD_W +: BCD_W] >= 4'd5)
                                            ? r_acc[gi*BCD_W +: BCD_W] + 4'd3
                                            : r_acc[gi*BCD_W +: BCD_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_LAST) w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_bcd <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bin <= bin;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                ST_SHIFT: begin
                    {r_acc, r_bin} <= {w_adj[ACC_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 1'b1;
                end
                ST_LATCH: r_bcd <= r_acc;
                default: ;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign done = (r_state == ST_LATCH);

endmodule

// File: rtl/display_scan_driver.sv
// Converts a 10-bit value to BCD and time-multiplexes it onto a 4-digit
// common-anode 7-segment display with optional leading-zero blanking.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] valor,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       listo
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

    logic [4*BCD_W-1:0] w_bcd;
    logic               w_done;
    logic [BCD_W-1:0]   w_digit [4];
    logic [3:0]         w_blank;
    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;

    bin_to_bcd_seq #(
        .BIN_W  (10),
        .DIGITS (4)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (valor),
        .bcd   (w_bcd),
        .done  (w_done)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign w_digit[gi] = w_bcd[gi*BCD_W +: BCD_W];
        end
        // A digit blanks only when every more-significant digit is blank too
        for (gi = 1; gi < 3; gi++) begin : g_blank
            assign w_blank[gi] = w_blank[gi+1] && (w_digit[gi] == '0);
        end
    endgenerate

    assign w_blank[3] = (BLANK_LZ != 0) && (w_digit[3] == '0);
    assign w_blank[0] = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= 4'b1111;
            r_seg   <= SEG_BLANK;
        end else begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank[r_idx] ? SEG_BLANK : seg_encode(w_digit[r_idx]);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign listo = w_done;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed checks of conversion timing, digit scanning, blanking, mid-conversion
// input changes and asynchronous reset for display_scan_driver.
module tb_display_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] valor;
    logic [3:0] an_a, an_b, an_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       listo_a, listo_b, listo_c;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] got [4];
    logic [3:0] an_seq [5];

    always #5 clk = ~clk;

    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .valor(valor), .an(an_a), .seg(seg_a), .listo(listo_a));
    display_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .valor(valor), .an(an_b), .seg(seg_b), .listo(listo_b));
    display_scan_driver #(.REFRESH_DIV(1), .BLANK_LZ(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .valor(valor), .an(an_c), .seg(seg_c), .listo(listo_c));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic wait_listo(output int n);
        bit found = 0;
        n = -1;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk); @(negedge clk);
            if (listo_a) begin
                found = 1;
                n = i;
            end
        end
        if (!found) check_val("listo_timeout", 32'(listo_a), 32'(1'b1));
    endtask

    task automatic set_value(input logic [9:0] v);
        int n;
        valor = v;
        wait_listo(n);
        wait_listo(n);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_digits(input bit sel, input string tag,
                                input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp_s [4];
        exp_s[3] = e3; exp_s[2] = e2; exp_s[1] = e1; exp_s[0] = e0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] target;
            bit found;
            target = ~(4'b0001 << k);
            found = 0;
            for (int i = 0; i < 24 && !found; i++) begin
                @(posedge clk); @(negedge clk);
                if ((sel ? an_b : an_a) == target) found = 1;
            end
            if (!found)
                check_val($sformatf("%s_an%0d_timeout", tag, k), 32'(sel ? an_b : an_a), 32'(target));
            else
                check_val($sformatf("%s_d%0d", tag, k), 32'(sel ? seg_b : seg_a), 32'(exp_s[k]));
        end
    endtask

    // dut_c scans one digit per clock, so four consecutive samples hold one latched result
    task automatic capture_c();
        for (int k = 0; k < 4; k++) got[k] = 7'h00;
        for (int s = 1; s <= 5; s++) begin
            @(posedge clk); @(negedge clk);
            if (s >= 2) begin
                case (an_c)
                    4'b1110: got[0] = seg_c;
                    4'b1101: got[1] = seg_c;
                    4'b1011: got[2] = seg_c;
                    4'b0111: got[3] = seg_c;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        int n;
        int edges;
        bit seen;
        logic [3:0] prev_an;
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011;
        an_seq[3] = 4'b0111; an_seq[4] = 4'b1110;

        rst_n = 1'b0;
        valor = 10'd0;
        repeat (3) @(negedge clk);
        check_val("rst_an",    32'(an_a),    32'(4'b1111));
        check_val("rst_seg",   32'(seg_a),   32'(SB));
        check_val("rst_listo", 32'(listo_a), 32'(1'b0));

        rst_n = 1'b1;
        edges = -1;
        seen  = 0;
        for (int e = 1; e <= 30 && !seen; e++) begin
            @(posedge clk); @(negedge clk);
            if (e == 1) begin
                check_val("first_an",  32'(an_a),  32'(4'b1110));
                check_val("first_seg", 32'(seg_a), 32'(S0));
            end
            if (e <= 5) check_val($sformatf("div1_an%0d", e), 32'(an_c), 32'(an_seq[e-1]));
            if (listo_a) begin
                seen  = 1;
                edges = e;
            end
        end
        // LATCH is the 12th cycle after release, i.e. after the 11th edge
        check_val("listo_latency", 32'(edges), 32'(11));
        @(posedge clk); @(negedge clk);
        check_val("listo_pulse_end", 32'(listo_a), 32'(1'b0));
        wait_listo(n);
        check_val("listo_period", 32'(n), 32'(11));
        check_digits(0, "val0", SB, SB, SB, S0);

        set_value(10'd1023);
        prev_an = an_a;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (an_a == 4'b1110 && prev_an != 4'b1110) seen = 1;
            prev_an = an_a;
        end
        check_val("scan_sync", 32'(seen), 32'(1'b1));
        check_val("scan_seg0", 32'(seg_a), 32'(S3));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("scan_an1",  32'(an_a),  32'(4'b1101));
        check_val("scan_seg1", 32'(seg_a), 32'(S2));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("scan_an2",  32'(an_a),  32'(4'b1011));
        check_val("scan_seg2", 32'(seg_a), 32'(S0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("scan_an3",  32'(an_a),  32'(4'b0111));
        check_val("scan_seg3", 32'(seg_a), 32'(S1));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("scan_wrap", 32'(an_a),  32'(4'b1110));

        set_value(10'd7);
        check_digits(0, "val7_lz",   SB, SB, SB, S7);
        check_digits(1, "val7_nolz", S0, S0, S0, S7);
        set_value(10'd105);
        check_digits(0, "val105", SB, S1, S0, S5);

        // Sit in the LATCH cycle, then IDLE samples 512 two edges later
        wait_listo(n);
        valor = 10'd512;
        repeat (4) @(posedge clk);
        @(negedge clk);
        valor = 10'd99;
        wait_listo(n);
        capture_c();
        check_val("mid_first_d3", 32'(got[3]), 32'(SB));
        check_val("mid_first_d2", 32'(got[2]), 32'(S5));
        check_val("mid_first_d1", 32'(got[1]), 32'(S1));
        check_val("mid_first_d0", 32'(got[0]), 32'(S2));
        wait_listo(n);
        capture_c();
        check_val("mid_next_d3", 32'(got[3]), 32'(SB));
        check_val("mid_next_d2", 32'(got[2]), 32'(SB));
        check_val("mid_next_d1", 32'(got[1]), 32'(S9));
        check_val("mid_next_d0", 32'(got[0]), 32'(S9));

        // Edge 2 after LATCH starts SHIFT cycle 1, edge 6 starts cycle 5
        wait_listo(n);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_an",    32'(an_a),    32'(4'b1111));
        check_val("arst_seg",   32'(seg_a),   32'(SB));
        check_val("arst_listo", 32'(listo_a), 32'(1'b0));
        check_val("arst_an_c",  32'(an_c),    32'(4'b1111));
        repeat (3) @(negedge clk);
        check_val("arst_hold_listo", 32'(listo_a), 32'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rerel_an",  32'(an_a),  32'(4'b1110));
        check_val("rerel_seg", 32'(seg_a), 32'(S0));
        wait_listo(n);
        check_val("rerel_latency", 32'(n), 32'(10));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low.
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot; legal range 1..2^20.
REQ-003 Parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled.
REQ-004 Port clk  input  1  system clock, rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port valor  input  10  unsigned binary value to display (0..1023), the selected measurement word.
REQ-007 Port an  output  4  digit enables, active-low one-hot; an[0] = units, an[3] = thousands.
REQ-008 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 Port listo  output  1  one-cycle pulse when a new BCD result is latched to the display.

Function
REQ-010 Converter FSM SHALL have states IDLE, SHIFT, LATCH.
REQ-011 IDLE: capture valor into a shift register and clear the 16-bit BCD accumulator; next state SHIFT, bit counter = 0.
REQ-012 SHIFT: per cycle, add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by 1; after exactly 10 SHIFT cycles, go to LATCH.
REQ-013 LATCH: copy the 4 BCD nibbles to the display digit registers, assert listo for this cycle only, then go to IDLE.
REQ-014 Conversion period SHALL be exactly 12 cycles; valor sampled in IDLE is displayed from the cycle after LATCH.
REQ-015 valor changes during SHIFT/LATCH SHALL NOT affect the result in progress; the next IDLE samples the new value.
REQ-016 Display digit registers SHALL hold their previous value throughout a conversion (no intermediate values visible).
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on the wrap cycle the 2-bit digit index increments, mod 4 (3 -> 0).
REQ-018 an and seg SHALL be registered, reflecting the current digit index and digit registers with one cycle latency.
REQ-019 an SHALL be 1110, 1101, 1011, 0111 for index 0, 1, 2, 3.
REQ-020 Segment codes 0..9 SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank = 1111111.
REQ-021 With BLANK_LZ=1: thousands blank if 0; hundreds blank if thousands and hundreds are 0; tens blank if the top three are 0; units never blank.
REQ-022 With BLANK_LZ=0 all four digits SHALL always be shown.
REQ-023 Nibble values 10..15 SHALL never reach the encoder; if present, the encoder outputs blank.

Reset
REQ-024 While rst_n=0: an=1111, seg=1111111, listo=0, FSM=IDLE, prescaler=0, digit index=0, digit and BCD registers=0.
REQ-025 Reset asserted mid-conversion SHALL abort it; the first conversion after release starts in IDLE on the first clock edge.
REQ-026 First clock after release: an=1110, seg=1000000 (units 0).

Structure
REQ-027 Shared package display_pkg SHALL hold the FSM state enum, the ten segment code constants, SEG_BLANK, and BCD_W=4.
REQ-028 The sequential converter SHALL be a sub-module bin_to_bcd_seq (ports clk, rst_n, bin, bcd, done); scanning and encoding stay in the top.
REQ-029 Prescaler width SHALL be clog2(REFRESH_DIV), minimum 1 bit.

Verification
REQ-030 Reset: rst_n=0 with valor=0 -> an=1111, seg=1111111; release -> listo at cycle 12, units shows 1000000, other digits 1111111.
REQ-031 valor=1023, REFRESH_DIV=4 -> after listo, an cycles 1110/1101/1011/0111 every 4 clocks with seg 0110000/0100100/1000000/1111001.
REQ-032 Blanking: valor=7 -> only units shows 1111000; valor=105 -> hundreds 1111001, tens 1000000 shown, thousands blank; BLANK_LZ=0, valor=7 -> 1000000 on three upper digits.
REQ-033 Mid-conversion change: valor=512, switched to 99 at SHIFT cycle 3 -> first listo latches 5,1,2; the following listo latches 9,9.
REQ-034 Reset mid-operation: rst_n low during SHIFT cycle 5 -> all outputs return to REQ-024 values immediately, with no listo pulse.
REQ-035 REFRESH_DIV=1 -> digit index advances every clock, an sequence 1110, 1101, 1011, 0111, 1110.
